// File: rtl/speaker_arbiter.sv
// Fixed-priority speaker arbiter: grants the speaker to one of three tone
// sources, generates its square wave, and inserts a silent gap on every handover.
module speaker_arbiter #(
    parameter int DIV_W      = 16,
    parameter int GAP_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             enable,
    input  logic [2:0]       req,
    input  logic [DIV_W-1:0] half_period0,
    input  logic [DIV_W-1:0] half_period1,
    input  logic [DIV_W-1:0] half_period2,
    output logic [2:0]       grant,
    output logic             speaker,
    output logic             active,
    output logic             preempted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [19:0]      GAP_LAST = 20'(GAP_CYCLES - 1);
    localparam logic [DIV_W-1:0] HP_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    function automatic logic [DIV_W-1:0] hp_mux(
        input logic [2:0]       sel,
        input logic [DIV_W-1:0] hp0,
        input logic [DIV_W-1:0] hp1,
        input logic [DIV_W-1:0] hp2
    );
        logic [DIV_W-1:0] v;
        v = '0;
        if (sel[0]) v = hp0;
        else if (sel[1]) v = hp1;
        else if (sel[2]) v = hp2;
        return v;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_grant, w_grant_nxt;
    logic [DIV_W-1:0] r_hp, w_hp_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [19:0]      r_gap_cnt, w_gap_cnt_nxt;
    logic             r_spk, w_spk_nxt;
    logic             r_pre, w_pre_nxt;

    logic [2:0]       w_win;
    logic [DIV_W-1:0] w_hp_win;
    logic [DIV_W-1:0] w_hp_own;
    logic             w_higher;
    logic             w_own_req;

    assign w_win     = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    assign w_hp_win  = hp_mux(w_win, half_period0, half_period1, half_period2);
    assign w_hp_own  = hp_mux(r_grant, half_period0, half_period1, half_period2);
    // One-hot minus one masks exactly the sources that outrank the owner.
    assign w_higher  = |(req & (r_grant - 3'd1));
    assign w_own_req = |(req & r_grant);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state   <= S_IDLE;
            r_grant   <= 3'b000;
            r_hp      <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_spk     <= 1'b0;
            r_pre     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_hp      <= w_hp_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_spk     <= w_spk_nxt;
            r_pre     <= w_pre_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_hp_nxt      = r_hp;
        w_cnt_nxt     = r_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_spk_nxt     = r_spk;
        w_pre_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_grant_nxt = 3'b000;
                w_spk_nxt   = 1'b0;
                w_cnt_nxt   = '0;
                if (enable && (req != 3'b000)) begin
                    w_state_nxt = S_PLAY;
                    w_grant_nxt = w_win;
                    w_hp_nxt    = w_hp_win;
                end
            end

            S_PLAY: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = 3'b000;
                    w_spk_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (w_higher || !w_own_req) begin
                    w_state_nxt   = S_GAP;
                    w_pre_nxt     = w_higher;
                    w_grant_nxt   = 3'b000;
                    w_spk_nxt     = 1'b0;
                    w_cnt_nxt     = '0;
                    w_gap_cnt_nxt = '0;
                end else if (r_hp == '0) begin
                    w_spk_nxt = 1'b0;
                    w_cnt_nxt = '0;
                    w_hp_nxt  = w_hp_own;
                end else if (r_cnt == r_hp - HP_ONE) begin
                    // New half-period is picked up only here, at the toggle.
                    w_spk_nxt = ~r_spk;
                    w_cnt_nxt = '0;
                    w_hp_nxt  = w_hp_own;
                end else begin
                    w_cnt_nxt = r_cnt + HP_ONE;
                end
            end

            S_GAP: begin
                w_grant_nxt = 3'b000;
                w_spk_nxt   = 1'b0;
                w_cnt_nxt   = '0;
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap_cnt == GAP_LAST) begin
                    if (req != 3'b000) begin
                        w_state_nxt = S_PLAY;
                        w_grant_nxt = w_win;
                        w_hp_nxt    = w_hp_win;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 20'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 3'b000;
                w_spk_nxt   = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign grant     = r_grant;
    assign speaker   = r_spk;
    assign active    = (r_state == S_PLAY);
    assign preempted = r_pre;

endmodule

// File: tb/tb_speaker_arbiter.sv
// Bench for speaker_arbiter: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a behavioural model.
module tb_speaker_arbiter;

    localparam int DIV_W = 16;
    localparam int GAP   = 4;

    logic             clk_clk     = 1'b0;
    logic             reset_reset = 1'b1;
    logic             enable      = 1'b0;
    logic [2:0]       req         = 3'b000;
    logic [DIV_W-1:0] hp0         = '0;
    logic [DIV_W-1:0] hp1         = '0;
    logic [DIV_W-1:0] hp2         = '0;
    logic [2:0]       grant;
    logic             speaker;
    logic             active;
    logic             preempted;

    speaker_arbiter #(.DIV_W(DIV_W), .GAP_CYCLES(GAP)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .enable      (enable),
        .req         (req),
        .half_period0(hp0),
        .half_period1(hp1),
        .half_period2(hp2),
        .grant       (grant),
        .speaker     (speaker),
        .active      (active),
        .preempted   (preempted)
    );

    always #5 clk_clk = ~clk_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 playing, 2 silent gap.
    int m_mode = 0, m_owner = 0, m_cur = 0, m_left = 0, m_gap_start = 0, cyc = 0;
    bit m_spk = 0, m_pre = 0;

    function automatic int hp_of(input int i);
        case (i)
            0:       return int'(hp0);
            1:       return int'(hp1);
            default: return int'(hp2);
        endcase
    endfunction

    function automatic int first_req(input logic [2:0] r);
        for (int i = 0; i < 3; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_play(input int w);
        m_mode  = 1;
        m_owner = w;
        m_cur   = hp_of(w);
        m_left  = m_cur;
        m_spk   = 0;
    endtask

    task automatic model_step();
        int w;
        cyc++;
        m_pre = 0;
        if (reset_reset) begin
            m_mode = 0;
            m_spk  = 0;
            return;
        end
        w = first_req(req);
        case (m_mode)
            0: if (enable && w >= 0) model_play(w);
            1: begin
                if (!enable) begin
                    m_mode = 0;
                    m_spk  = 0;
                end else if (w >= 0 && w < m_owner) begin
                    m_mode = 2; m_pre = 1; m_spk = 0; m_gap_start = cyc;
                end else if (!req[m_owner]) begin
                    m_mode = 2; m_spk = 0; m_gap_start = cyc;
                end else if (m_cur == 0) begin
                    m_spk  = 0;
                    m_cur  = hp_of(m_owner);
                    m_left = m_cur;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_spk  = !m_spk;
                        m_cur  = hp_of(m_owner);
                        m_left = m_cur;
                    end
                end
            end
            default: begin
                if (!enable) m_mode = 0;
                else if (cyc - m_gap_start == GAP) begin
                    if (w >= 0) model_play(w);
                    else m_mode = 0;
                end
            end
        endcase
    endtask

    always @(posedge clk_clk) begin
        model_step();
        #1;
        check("cmp_grant", int'(grant), (m_mode == 1) ? (1 << m_owner) : 0);
        check("cmp_speaker", int'(speaker), int'(m_spk));
        check("cmp_active", int'(active), (m_mode == 1) ? 1 : 0);
        check("cmp_preempted", int'(preempted), int'(m_pre));
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    initial begin
        wait_n(3);
        check("rst_grant", int'(grant), 0);
        check("rst_speaker", int'(speaker), 0);
        check("rst_active", int'(active), 0);
        check("rst_preempted", int'(preempted), 0);
        reset_reset = 1'b0;
        enable      = 1'b1;
        wait_n(1);

        // single source, half-period 3
        hp2 = 16'd3; req = 3'b100;
        wait_n(1);
        check("single_grant", int'(grant), 4);
        check("single_active", int'(active), 1);
        check("single_spk0", int'(speaker), 0);
        wait_n(2); check("single_spk_lo", int'(speaker), 0);
        wait_n(1); check("single_rise", int'(speaker), 1);
        wait_n(3); check("single_fall", int'(speaker), 0);

        // alarm preempts jukebox
        hp0 = 16'd2; req = 3'b101;
        wait_n(1);
        check("pre_grant", int'(grant), 0);
        check("pre_pulse", int'(preempted), 1);
        check("pre_spk", int'(speaker), 0);
        wait_n(1); check("pre_pulse_end", int'(preempted), 0);
        wait_n(2); check("pre_gap_grant", int'(grant), 0);
        wait_n(1);
        check("pre_new_grant", int'(grant), 1);
        check("pre_new_spk", int'(speaker), 0);
        wait_n(2); check("pre_rise", int'(speaker), 1);
        wait_n(2); check("pre_fall", int'(speaker), 0);

        // release to piano, then change its frequency mid half-period
        hp1 = 16'd5; req = 3'b010;
        wait_n(1);
        check("rel_grant", int'(grant), 0);
        check("rel_nopre", int'(preempted), 0);
        wait_n(4); check("freq_grant", int'(grant), 2);
        wait_n(2); hp1 = 16'd2;
        wait_n(2); check("freq_lo", int'(speaker), 0);
        wait_n(1); check("freq_rise5", int'(speaker), 1);
        wait_n(1); check("freq_hold", int'(speaker), 1);
        wait_n(1); check("freq_fall2", int'(speaker), 0);
        wait_n(2); check("freq_rise2", int'(speaker), 1);

        // mute, then zero half-period keeps grant but stays silent
        enable = 1'b0; req = 3'b011;
        wait_n(1);
        check("mute_grant", int'(grant), 0);
        check("mute_active", int'(active), 0);
        wait_n(3); check("mute_stay", int'(grant), 0);
        hp1 = 16'd0; enable = 1'b1; req = 3'b010;
        wait_n(1); check("zero_grant", int'(grant), 2);
        wait_n(5);
        check("zero_spk", int'(speaker), 0);
        check("zero_active", int'(active), 1);

        // drop jukebox and raise piano in the same cycle
        req = 3'b100; hp2 = 16'd5;
        wait_n(1); check("sim_rel", int'(grant), 0);
        wait_n(4); check("sim_setup", int'(grant), 4);
        hp1 = 16'd2; req = 3'b010;
        wait_n(1);
        check("sim_grant", int'(grant), 0);
        check("sim_pre", int'(preempted), 1);
        wait_n(3); check("sim_gap", int'(grant), 0);
        wait_n(1); check("sim_new", int'(grant), 2);
        wait_n(2); check("sim_rise", int'(speaker), 1);

        // asynchronous reset mid-tone
        reset_reset = 1'b1;
        #1;
        check("rst_tone_grant", int'(grant), 0);
        check("rst_tone_spk", int'(speaker), 0);
        check("rst_tone_active", int'(active), 0);
        wait_n(1);
        reset_reset = 1'b0; hp2 = 16'd2; req = 3'b100;
        wait_n(1); check("restart_grant", int'(grant), 4);

        // asynchronous reset mid-gap, then direct grant from idle
        req = 3'b000;
        wait_n(2); check("gap_grant", int'(grant), 0);
        reset_reset = 1'b1;
        #1;
        check("rst_gap_grant", int'(grant), 0);
        check("rst_gap_pre", int'(preempted), 0);
        check("rst_gap_active", int'(active), 0);
        wait_n(1);
        reset_reset = 1'b0; req = 3'b001;
        wait_n(1); check("idle_grant", int'(grant), 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_clk);
            enable = ($urandom_range(31) != 0);
            if ($urandom_range(7) == 0)  req = 3'($urandom_range(7));
            if ($urandom_range(15) == 0) hp0 = 16'($urandom_range(6));
            if ($urandom_range(15) == 0) hp1 = 16'($urandom_range(6));
            if ($urandom_range(15) == 0) hp2 = 16'($urandom_range(6));
        end

        wait_n(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
